skyking_text_sequencer: RTL and testbench

// Frame-rate controller for the SkyKing VGA letter datapath. Reveals the banner letters one at
// a time (typewriter), holds the full line, erases it back to front, then loops. Drives the
// per-letter enable mask and cursor position/blink that gate the letter-region decoders.

---
 rtl/skyking_text_sequencer.sv | 165 ++++++++++++++++
 tb/tb_skyking_text_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/skyking_text_sequencer.sv
// SkyKing banner sequencer: frame-tick driven typewriter reveal, hold, back-to-front erase, loop.
// Produces the per-letter enable mask and the cursor slot/visibility for the letter decoders.
module skyking_text_sequencer #(
  parameter int unsigned NUM_LETTERS  = 17,
  parameter int unsigned BLANK_FRAMES = 30,
  parameter int unsigned CHAR_FRAMES  = 8,
  parameter int unsigned HOLD_FRAMES  = 180,
  parameter int unsigned BLINK_FRAMES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 vsync,
  input  logic                                 pause,
  input  logic                                 restart,
  output logic [NUM_LETTERS-1:0]               letter_en,
  output logic [$clog2(NUM_LETTERS+1)-1:0]     cursor_idx,
  output logic                                 cursor_on,
  output logic [1:0]                           state,
  output logic                                 cycle_done
);

  localparam int unsigned CW   = $clog2(NUM_LETTERS + 1);
  localparam int unsigned FMax = (BLANK_FRAMES > CHAR_FRAMES) ?
                                 ((BLANK_FRAMES > HOLD_FRAMES) ? BLANK_FRAMES : HOLD_FRAMES) :
                                 ((CHAR_FRAMES > HOLD_FRAMES) ? CHAR_FRAMES : HOLD_FRAMES);
  localparam int unsigned FW   = $clog2(FMax + 1);
  localparam int unsigned BW   = $clog2(BLINK_FRAMES + 1);

  // Timer values on which the next qualifying tick completes the period.
  localparam logic [FW-1:0] BlankLast = FW'(BLANK_FRAMES - 1);
  localparam logic [FW-1:0] CharLast  = FW'(CHAR_FRAMES - 1);
  localparam logic [FW-1:0] HoldLast  = FW'(HOLD_FRAMES - 1);
  localparam logic [BW-1:0] BlinkLast = BW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] LastSlot  = CW'(NUM_LETTERS - 1);
  localparam logic [CW-1:0] Full      = CW'(NUM_LETTERS);

  typedef enum logic [1:0] {
    StBlank = 2'd0,
    StType  = 2'd1,
    StHold  = 2'd2,
    StErase = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          count_q, count_d;
  logic [FW-1:0]          ftimer_q, ftimer_d;
  logic [BW-1:0]          btimer_q, btimer_d;
  logic                   phase_q, phase_d;
  logic                   vsync_q;
  logic                   tick;
  logic                   cycle_done_d;
  logic [NUM_LETTERS-1:0] letter_en_d;
  logic [CW-1:0]          cursor_idx_d;
  logic                   cursor_on_d;

  assign tick  = vsync & ~vsync_q;
  assign state = state_q;

  // State register: sequencing state, timers and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StBlank;
      count_q    <= '0;
      ftimer_q   <= '0;
      btimer_q   <= '0;
      phase_q    <= 1'b0;
      vsync_q    <= 1'b1;  // vsync already high at release must not count as a tick
      letter_en  <= '0;
      cursor_idx <= '0;
      cursor_on  <= 1'b0;
      cycle_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ftimer_q   <= ftimer_d;
      btimer_q   <= btimer_d;
      phase_q    <= phase_d;
      vsync_q    <= vsync;
      letter_en  <= letter_en_d;
      cursor_idx <= cursor_idx_d;
      cursor_on  <= cursor_on_d;
      cycle_done <= cycle_done_d;
    end
  end

  // Next-state: restart beats pause beats tick; blink keeps running through pause.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    ftimer_d     = ftimer_q;
    btimer_d     = btimer_q;
    phase_d      = phase_q;
    cycle_done_d = 1'b0;
    if (restart) begin
      state_d  = StBlank;
      count_d  = '0;
      ftimer_d = '0;
      btimer_d = '0;
      phase_d  = 1'b0;
    end else begin
      if (tick) begin
        if (btimer_q == BlinkLast) begin
          btimer_d = '0;
          phase_d  = ~phase_q;
        end else begin
          btimer_d = btimer_q + BW'(1);
        end
      end
      if (tick && !pause) begin
        unique case (state_q)
          StBlank: begin
            if (ftimer_q == BlankLast) begin
              state_d  = StType;
              count_d  = '0;
              ftimer_d = '0;
            end else begin
              ftimer_d = ftimer_q + FW'(1);
            end
          end
          StType: begin
            if (ftimer_q == CharLast) begin
              ftimer_d = '0;
              count_d  = count_q + CW'(1);
              if (count_q == LastSlot) state_d = StHold;
            end else begin
              ftimer_d = ftimer_q + FW'(1);
            end
          end
          StHold: begin
            if (ftimer_q == HoldLast) begin
              state_d  = StErase;
              ftimer_d = '0;
            end else begin
              ftimer_d = ftimer_q + FW'(1);
            end
          end
          StErase: begin
            ftimer_d = '0;
            count_d  = count_q - CW'(1);
            if (count_q <= CW'(1)) begin
              count_d      = '0;
              state_d      = StBlank;
              cycle_done_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Output decode from next-state values so outputs land on the same edge as the state.
  always_comb begin
    letter_en_d = '0;
    for (int i = 0; i < int'(NUM_LETTERS); i++) begin
      letter_en_d[i] = (count_d > CW'(i));
    end
    cursor_idx_d = (count_d >= Full) ? LastSlot : count_d;
    unique case (state_d)
      StType:  cursor_on_d = 1'b1;
      StHold:  cursor_on_d = phase_d;
      default: cursor_on_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_skyking_text_sequencer.sv
// Directed bench for skyking_text_sequencer with small frame counts; expected outputs come from
// a frame-number model pushed to a scoreboard and popped after each output update.
module tb_skyking_text_sequencer;

  localparam int NL    = 17;
  localparam int BLANK = 3;
  localparam int CHAR  = 2;
  localparam int HOLD  = 4;
  localparam int BLINK = 2;
  localparam int TYPE_END = BLANK + NL * CHAR;          // 37
  localparam int HOLD_END = TYPE_END + HOLD;            // 41
  localparam int LOOP     = HOLD_END + NL;              // 58

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        pause;
  logic        restart;
  logic [16:0] letter_en;
  logic [4:0]  cursor_idx;
  logic        cursor_on;
  logic [1:0]  state;
  logic        cycle_done;

  int n_tests = 0;
  int n_fail  = 0;
  int seq_n   = 0;  // qualifying ticks into the current loop
  int all_n   = 0;  // every tick since reset/restart (drives blink)

  typedef struct {
    string       tag;
    logic [1:0]  st;
    logic [16:0] le;
    logic [4:0]  ci;
    logic        co;
    logic        cd;
  } exp_t;

  exp_t sb[$];

  skyking_text_sequencer #(
    .NUM_LETTERS (NL),
    .BLANK_FRAMES(BLANK),
    .CHAR_FRAMES (CHAR),
    .HOLD_FRAMES (HOLD),
    .BLINK_FRAMES(BLINK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .pause     (pause),
    .restart   (restart),
    .letter_en (letter_en),
    .cursor_idx(cursor_idx),
    .cursor_on (cursor_on),
    .state     (state),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  function automatic exp_t model(input string tag, input int n, input int a, input logic cd);
    exp_t e;
    int   cnt;
    e.tag = tag;
    if (n < BLANK) begin
      e.st = 2'd0; cnt = 0;
    end else if (n < TYPE_END) begin
      e.st = 2'd1; cnt = (n - BLANK) / CHAR;
    end else if (n < HOLD_END) begin
      e.st = 2'd2; cnt = NL;
    end else begin
      e.st = 2'd3; cnt = NL - (n - HOLD_END);
    end
    e.le = 17'((32'd1 << cnt) - 32'd1);
    e.ci = 5'((cnt > NL - 1) ? NL - 1 : cnt);
    if (e.st == 2'd1)      e.co = 1'b1;
    else if (e.st == 2'd2) e.co = 1'(((a / BLINK) % 2));
    else                   e.co = 1'b0;
    e.cd = cd;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    n_tests++;
    assert (sb.size() > 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty got size %0d exp >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests++;
      assert (state === e.st) else begin
        n_fail++; $error("FAIL %s state got %0d exp %0d", e.tag, state, e.st);
      end
      n_tests++;
      assert (letter_en === e.le) else begin
        n_fail++; $error("FAIL %s letter_en got %h exp %h", e.tag, letter_en, e.le);
      end
      n_tests++;
      assert (cursor_idx === e.ci) else begin
        n_fail++; $error("FAIL %s cursor_idx got %0d exp %0d", e.tag, cursor_idx, e.ci);
      end
      n_tests++;
      assert (cursor_on === e.co) else begin
        n_fail++; $error("FAIL %s cursor_on got %b exp %b", e.tag, cursor_on, e.co);
      end
      n_tests++;
      assert (cycle_done === e.cd) else begin
        n_fail++; $error("FAIL %s cycle_done got %b exp %b", e.tag, cycle_done, e.cd);
      end
    end
  endtask

  // One frame: vsync rises for hold cycles, then falls; checks after the edge and one cycle later.
  task automatic do_tick(input string tag, input int hold);
    logic wrap;
    @(negedge clk);
    vsync = 1'b1;
    all_n++;
    wrap = 1'b0;
    if (!pause) begin
      seq_n++;
      if (seq_n == LOOP) begin
        seq_n = 0;
        wrap  = 1'b1;
      end
    end
    sb.push_back(model(tag, seq_n, all_n, wrap));
    @(negedge clk);
    check_out();
    for (int i = 1; i < hold; i++) @(negedge clk);
    vsync = 1'b0;
    sb.push_back(model({tag, "_post"}, seq_n, all_n, 1'b0));
    @(negedge clk);
    check_out();
  endtask

  initial begin
    rst_n   = 1'b0;
    vsync   = 1'b1;
    pause   = 1'b0;
    restart = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // vsync still high after release: no tick expected
    sb.push_back(model("reset", 0, 0, 1'b0));
    @(negedge clk);
    check_out();
    sb.push_back(model("reset_hold_vsync", 0, 0, 1'b0));
    @(negedge clk);
    check_out();
    vsync = 1'b0;
    @(negedge clk);

    // Full loop, some frames with vsync held high for several clocks
    for (int t = 1; t <= LOOP; t++) begin
      do_tick($sformatf("loop1_t%0d", t), (t % 5 == 0) ? 4 : 1);
    end

    // Second pass into HOLD, then restart coincident with a tick
    for (int t = 1; t <= TYPE_END + 1; t++) begin
      do_tick($sformatf("loop2_t%0d", t), 1);
    end
    @(negedge clk);
    vsync   = 1'b1;
    restart = 1'b1;
    seq_n   = 0;
    all_n   = 0;
    sb.push_back(model("restart_in_hold", 0, 0, 1'b0));
    @(negedge clk);
    restart = 1'b0;
    check_out();
    vsync = 1'b0;
    sb.push_back(model("restart_post", 0, 0, 1'b0));
    @(negedge clk);
    check_out();

    // Pause mid-TYPE for 20 frames, then resume
    for (int t = 1; t <= 10; t++) begin
      do_tick($sformatf("pre_pause_t%0d", t), 1);
    end
    @(negedge clk);
    pause = 1'b1;
    for (int t = 1; t <= 20; t++) begin
      do_tick($sformatf("paused_t%0d", t), 1);
    end
    @(negedge clk);
    pause = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      do_tick($sformatf("resume_t%0d", t), 1);
    end

    n_tests++;
    assert (sb.size() === 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drained got size %0d exp 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
